// File: rtl/vc_fifo_bank_pkg.sv
// vc_fifo_pkg: shared width helpers for the multi-channel FIFO bank.
// Channel-index, fill-count and pointer widths plus the fill-slice index.
package vc_fifo_pkg;

    // Channel index width; a bank always has at least one index bit.
    function automatic int cw_of(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Fill counter must hold 0..DEPTH inclusive.
    function automatic int fw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width addresses 0..DEPTH-1.
    function automatic int pw_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // LSB of channel ch inside the packed fill vector.
    function automatic int fill_lsb(input int ch, input int fw);
        return ch * fw;
    endfunction

endpackage

// File: rtl/vc_fifo_bank_if.sv
// vc_fifo_bank_if: write/read port bundle of the VC FIFO bank.
// master drives wr_*/rd_en/rd_ch; slave returns rd_data/rd_valid.
interface vc_fifo_bank_if #(
    parameter int BW = 8,
    parameter int CW = 2
);
    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [BW-1:0] wr_data;
    logic          rd_en;
    logic [CW-1:0] rd_ch;
    logic [BW-1:0] rd_data;
    logic          rd_valid;

    modport master (
        output wr_en, wr_ch, wr_data, rd_en, rd_ch,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_ch, wr_data, rd_en, rd_ch,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/vc_fifo_bank_lane.sv
// vc_fifo_lane: one channel of the bank -- storage, pointers, fill,
// status flags, hysteresis pause and sticky errors. Hits decoded above.
module vc_fifo_lane
    import vc_fifo_pkg::*;
#(
    parameter int BW    = 8,
    parameter int DEPTH = 8,
    parameter int FW    = fw_of(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_hit,
    input  logic          rd_hit,
    input  logic [BW-1:0] wr_data,
    input  logic [FW-1:0] umbral_bajo,
    input  logic [FW-1:0] umbral_alto,
    input  logic          err_clr,
    output logic          rd_acc,
    output logic [BW-1:0] rd_word,
    output logic [FW-1:0] fill,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          pause,
    output logic          err_overrun,
    output logic          err_underrun
);
    localparam int PW = pw_of(DEPTH);
    localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

    logic [BW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [FW-1:0] fill_next;
    logic          wr_acc;

    // Explicit wrap so non power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign full         = (fill == DEPTH_F);
    assign empty        = (fill == '0);
    assign almost_full  = (fill >= umbral_alto);
    assign almost_empty = (fill <= umbral_bajo);

    // A full lane still takes a write when the same cycle pops it.
    assign rd_acc  = rd_hit && !empty;
    assign wr_acc  = wr_hit && (!full || rd_acc);
    assign rd_word = mem[rd_ptr];

    always_comb begin
        fill_next = fill;
        if (wr_acc && !rd_acc) begin
            fill_next = fill + FW'(1);
        end else if (rd_acc && !wr_acc) begin
            fill_next = fill - FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill         <= '0;
            pause        <= 1'b0;
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            fill <= fill_next;
            // Set wins over clear when thresholds overlap.
            if (fill_next >= umbral_alto) begin
                pause <= 1'b1;
            end else if (fill_next <= umbral_bajo) begin
                pause <= 1'b0;
            end
            // A fresh error beats a same-cycle clear.
            err_overrun  <= (err_overrun && !err_clr)
                          || (wr_hit && !wr_acc);
            err_underrun <= (err_underrun && !err_clr)
                          || (rd_hit && empty);
        end
    end

    // Storage is not reset; pointers make stale data invisible.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/vc_fifo_bank.sv
// vc_fifo_bank: NCH independent FIFOs behind one write and one read port.
// Ports: clk, reset, bus (wr/rd handshake), thresholds, err_clr, status vectors.
module vc_fifo_bank
    import vc_fifo_pkg::*;
#(
    parameter int BW    = 8,
    parameter int DEPTH = 8,
    parameter int NCH   = 4,
    parameter int CW    = cw_of(NCH),
    parameter int FW    = fw_of(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    vc_fifo_bank_if.slave     bus,
    input  logic [FW-1:0]     umbral_bajo,
    input  logic [FW-1:0]     umbral_alto,
    input  logic              err_clr,
    output logic [NCH-1:0]    full,
    output logic [NCH-1:0]    empty,
    output logic [NCH-1:0]    almost_full,
    output logic [NCH-1:0]    almost_empty,
    output logic [NCH-1:0]    pause,
    output logic [NCH*FW-1:0] fill,
    output logic [NCH-1:0]    err_overrun,
    output logic [NCH-1:0]    err_underrun,
    output logic              error_output
);
    logic [NCH-1:0] wr_hit;
    logic [NCH-1:0] rd_hit;
    logic [NCH-1:0] rd_acc;
    logic [BW-1:0]  words [NCH];
    logic [BW-1:0]  rd_word_n;
    logic [BW-1:0]  rd_data_q;
    logic           rd_valid_q;

    // Out-of-range channel indices match no lane and are dropped.
    for (genvar c = 0; c < NCH; c++) begin : g_lane
        assign wr_hit[c] = bus.wr_en && (bus.wr_ch == CW'(c));
        assign rd_hit[c] = bus.rd_en && (bus.rd_ch == CW'(c));

        vc_fifo_lane #(
            .BW    (BW),
            .DEPTH (DEPTH),
            .FW    (FW)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .wr_hit       (wr_hit[c]),
            .rd_hit       (rd_hit[c]),
            .wr_data      (bus.wr_data),
            .umbral_bajo  (umbral_bajo),
            .umbral_alto  (umbral_alto),
            .err_clr      (err_clr),
            .rd_acc       (rd_acc[c]),
            .rd_word      (words[c]),
            .fill         (fill[fill_lsb(c, FW) +: FW]),
            .full         (full[c]),
            .empty        (empty[c]),
            .almost_full  (almost_full[c]),
            .almost_empty (almost_empty[c]),
            .pause        (pause[c]),
            .err_overrun  (err_overrun[c]),
            .err_underrun (err_underrun[c])
        );
    end

    // At most one lane accepts a read per cycle.
    always_comb begin
        rd_word_n = '0;
        for (int c = 0; c < NCH; c++) begin
            if (rd_acc[c]) begin
                rd_word_n = words[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= |rd_acc;
            rd_data_q  <= rd_word_n;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign error_output = |{err_overrun, err_underrun};

endmodule

// File: tb/tb_vc_fifo_bank.sv
// tb_vc_fifo_bank: table vectors, directed corner sequences and random
// traffic checked against a queue-based model of the FIFO bank.
module tb_vc_fifo_bank;
    import vc_fifo_pkg::*;

    localparam int BW    = 8;
    localparam int DEPTH = 8;
    localparam int NCH   = 4;
    localparam int CW    = 2;
    localparam int FW    = 4;
    localparam int BAJO  = 2;
    localparam int ALTO  = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [FW-1:0]     umbral_bajo;
    logic [FW-1:0]     umbral_alto;
    logic              err_clr;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    empty;
    logic [NCH-1:0]    almost_full;
    logic [NCH-1:0]    almost_empty;
    logic [NCH-1:0]    pause;
    logic [NCH*FW-1:0] fill;
    logic [NCH-1:0]    err_overrun;
    logic [NCH-1:0]    err_underrun;
    logic              error_output;

    vc_fifo_bank_if #(.BW(BW), .CW(CW)) bus ();

    vc_fifo_bank #(
        .BW    (BW),
        .DEPTH (DEPTH),
        .NCH   (NCH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .umbral_bajo  (umbral_bajo),
        .umbral_alto  (umbral_alto),
        .err_clr      (err_clr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .pause        (pause),
        .fill         (fill),
        .err_overrun  (err_overrun),
        .err_underrun (err_underrun),
        .error_output (error_output)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per channel.
    logic [7:0] mq [NCH][$];
    bit   [NCH-1:0] m_ov;
    bit   [NCH-1:0] m_un;
    bit   [NCH-1:0] m_pause;
    bit             m_valid;
    logic [7:0]     m_data;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       w;
        logic [1:0] wc;
        logic [7:0] wd;
        logic       r;
        logic [1:0] rc;
        logic       ev;
        logic [7:0] ed;
        logic [3:0] ef;
        logic       efull;
        logic       eempty;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] fill_of(input int c);
        return fill[c*FW +: FW];
    endfunction

    task automatic model_clk();
        bit ra;
        bit wa;
        int rc;
        int wc;
        if (reset) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_ov    = '0;
            m_un    = '0;
            m_pause = '0;
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            rc = int'(bus.rd_ch);
            wc = int'(bus.wr_ch);
            ra = bus.rd_en && (mq[rc].size() > 0);
            wa = bus.wr_en && ((mq[wc].size() < DEPTH) || (ra && rc == wc));
            for (int c = 0; c < NCH; c++) begin
                m_ov[c] = (m_ov[c] && !err_clr)
                        || (bus.wr_en && !wa && wc == c);
                m_un[c] = (m_un[c] && !err_clr)
                        || (bus.rd_en && !ra && rc == c);
            end
            m_valid = ra;
            m_data  = ra ? mq[rc].pop_front() : 8'h00;
            if (wa) mq[wc].push_back(bus.wr_data);
            for (int c = 0; c < NCH; c++) begin
                if (mq[c].size() >= ALTO) m_pause[c] = 1'b1;
                else if (mq[c].size() <= BAJO) m_pause[c] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        logic [NCH-1:0]    e_full;
        logic [NCH-1:0]    e_empty;
        logic [NCH-1:0]    e_af;
        logic [NCH-1:0]    e_ae;
        logic [NCH*FW-1:0] e_fill;
        for (int c = 0; c < NCH; c++) begin
            e_full[c]          = (mq[c].size() == DEPTH);
            e_empty[c]         = (mq[c].size() == 0);
            e_af[c]            = (mq[c].size() >= ALTO);
            e_ae[c]            = (mq[c].size() <= BAJO);
            e_fill[c*FW +: FW] = FW'(mq[c].size());
        end
        chk("m_rd_valid", 32'(bus.rd_valid), 32'(m_valid));
        chk("m_rd_data", 32'(bus.rd_data), 32'(m_data));
        chk("m_full", 32'(full), 32'(e_full));
        chk("m_empty", 32'(empty), 32'(e_empty));
        chk("m_almost_full", 32'(almost_full), 32'(e_af));
        chk("m_almost_empty", 32'(almost_empty), 32'(e_ae));
        chk("m_pause", 32'(pause), 32'(m_pause));
        chk("m_fill", 32'(fill), 32'(e_fill));
        chk("m_err_overrun", 32'(err_overrun), 32'(m_ov));
        chk("m_err_underrun", 32'(err_underrun), 32'(m_un));
        chk("m_error_output", 32'(error_output), 32'(|{m_ov, m_un}));
    endtask

    task automatic step();
        @(posedge clk);
        model_clk();
        #1;
        check_all();
    endtask

    task automatic set_in(input logic w, input int wc, input logic [7:0] wd,
                          input logic r, input int rc);
        bus.wr_en   = w;
        bus.wr_ch   = CW'(wc);
        bus.wr_data = wd;
        bus.rd_en   = r;
        bus.rd_ch   = CW'(rc);
    endtask

    task automatic idle();
        set_in(1'b0, 0, 8'h00, 1'b0, 0);
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        umbral_bajo = FW'(BAJO);
        umbral_alto = FW'(ALTO);
        reset       = 1'b1;
        idle();
        step();
        step();
        chk("rst_empty", 32'(empty), 32'hf);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("rst_err", 32'(error_output), 32'h0);
        reset = 1'b0;

        // Fill ch2 with 0x11..0x18, then drain it.
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, 2'd2, 8'(8'h11 + i), 1'b0, 2'd0,
                       1'b0, 8'h00, 4'(i + 1), (i == 7), 1'b0};
            tbl[8+i] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2,
                         1'b1, 8'(8'h11 + i), 4'(7 - i), 1'b0, (i == 7)};
        end
        tbl[16] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0,
                    1'b0, 8'h00, 4'd0, 1'b0, 1'b1};
        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].w, int'(tbl[i].wc), tbl[i].wd,
                   tbl[i].r, int'(tbl[i].rc));
            step();
            chk($sformatf("t%0d_valid", i), 32'(bus.rd_valid), 32'(tbl[i].ev));
            chk($sformatf("t%0d_data", i), 32'(bus.rd_data), 32'(tbl[i].ed));
            chk($sformatf("t%0d_fill2", i), 32'(fill_of(2)), 32'(tbl[i].ef));
            chk($sformatf("t%0d_full2", i), 32'(full[2]), 32'(tbl[i].efull));
            chk($sformatf("t%0d_empty2", i), 32'(empty[2]), 32'(tbl[i].eempty));
        end

        // Full ch1: simultaneous read+write accepted, lone write rejected.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1, 8'(8'h20 + i), 1'b0, 0);
            step();
        end
        chk("b_full1", 32'(full[1]), 32'h1);
        set_in(1'b1, 1, 8'hAA, 1'b1, 1);
        step();
        chk("b_rw_fill1", 32'(fill_of(1)), 32'd8);
        chk("b_rw_ov1", 32'(err_overrun[1]), 32'h0);
        chk("b_rw_data", 32'(bus.rd_data), 32'h20);
        set_in(1'b1, 1, 8'hBB, 1'b0, 0);
        step();
        chk("b_w_ov1", 32'(err_overrun[1]), 32'h1);
        chk("b_w_errout", 32'(error_output), 32'h1);
        chk("b_w_fill1", 32'(fill_of(1)), 32'd8);

        // Empty ch3: same-cycle write does not fall through.
        do_reset();
        set_in(1'b1, 3, 8'h33, 1'b1, 3);
        step();
        chk("c_valid", 32'(bus.rd_valid), 32'h0);
        chk("c_un3", 32'(err_underrun[3]), 32'h1);
        chk("c_fill3", 32'(fill_of(3)), 32'd1);
        idle();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("c_clr_un3", 32'(err_underrun[3]), 32'h0);
        chk("c_clr_errout", 32'(error_output), 32'h0);

        // Hysteresis on ch0.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            set_in(1'b1, 0, 8'(k), 1'b0, 0);
            step();
            chk($sformatf("d_up%0d_pause0", k), 32'(pause[0]), 32'(k == 6));
        end
        for (int k = 5; k >= 2; k--) begin
            set_in(1'b0, 0, 8'h00, 1'b1, 0);
            step();
            chk($sformatf("d_dn%0d_pause0", k), 32'(pause[0]), 32'(k != 2));
        end
        for (int k = 3; k <= 5; k++) begin
            set_in(1'b1, 0, 8'(k), 1'b0, 0);
            step();
            chk($sformatf("d_re%0d_pause0", k), 32'(pause[0]), 32'h0);
        end

        // Pointer wrap on ch0 with alternating write/read.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 0, 8'(8'h40 + i), 1'b0, 0);
            step();
            chk($sformatf("e%0d_fill_w", i), 32'(fill_of(0)), 32'd1);
            set_in(1'b0, 0, 8'h00, 1'b1, 0);
            step();
            chk($sformatf("e%0d_data", i), 32'(bus.rd_data), 32'(8'h40 + i));
            chk($sformatf("e%0d_valid", i), 32'(bus.rd_valid), 32'h1);
        end
        chk("e_errout", 32'(error_output), 32'h0);

        // Reset mid-burst.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1, 8'(8'h50 + i), 1'b0, 0);
            step();
        end
        chk("f_pre_fill1", 32'(fill_of(1)), 32'd5);
        set_in(1'b1, 1, 8'h55, 1'b1, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("f_fill1", 32'(fill_of(1)), 32'd0);
        chk("f_empty", 32'(empty), 32'hf);
        chk("f_valid", 32'(bus.rd_valid), 32'h0);
        chk("f_pause", 32'(pause), 32'h0);
        chk("f_err", 32'({err_overrun, err_underrun}), 32'h0);

        // Random traffic against the model.
        idle();
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(0, 249) == 0);
            set_in($urandom_range(0, 99) < 60, int'($urandom_range(0, 3)),
                   8'($urandom), $urandom_range(0, 99) < 45,
                   int'($urandom_range(0, 3)));
            err_clr = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
